// File: rtl/prog_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// prog_mem_arbiter_if
//   Bundles the three buses around the program-memory arbiter:
//     - CPU fetch port   : cpu_req/cpu_addr in, cpu_gnt/cpu_rdata/cpu_rvalid/
//                          cpu_stall out
//     - loader port      : ld_req/ld_we/ld_addr/ld_wdata/ld_lock in,
//                          ld_gnt/ld_rdata/ld_rvalid out
//     - memory port      : mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in
//   slave  : the arbiter's view (requests in, grants/memory commands out)
//   master : the view of the surrounding requesters and memory
// ---------------------------------------------------------------------------
interface prog_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    // CPU fetch port
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_gnt;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              cpu_stall;

    // host program-loader port
    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_lock;
    logic              ld_gnt;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_rvalid;

    // single-port synchronous program RAM
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_addr,
        output cpu_gnt, cpu_rdata, cpu_rvalid, cpu_stall,
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        output ld_gnt, ld_rdata, ld_rvalid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_addr,
        input  cpu_gnt, cpu_rdata, cpu_rvalid, cpu_stall,
        output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        input  ld_gnt, ld_rdata, ld_rvalid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/prog_mem_arbiter.sv
// ---------------------------------------------------------------------------
// prog_mem_arbiter
//   Shares one single-port synchronous program RAM between the LED CPU
//   instruction fetch and the host program loader, so a program can be
//   written or read back while the CPU runs.
//
//   Ports
//     clk  : system clock, rising edge
//     rst  : synchronous, active-high reset
//     bus  : prog_mem_arbiter_if.slave (CPU port, loader port, memory port)
//
//   Arbitration (one grant per cycle, decided combinationally):
//     ld_lock          -> loader only, CPU never granted
//     loader waited MAX_WAIT cycles -> loader
//     cpu_req          -> CPU
//     ld_req           -> loader
//   Read data comes back one cycle after the grant; a one-entry tag records
//   who owns the returning word.
// ---------------------------------------------------------------------------
module prog_mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input logic                 clk,
    input logic                 rst,
    prog_mem_arbiter_if.slave   bus
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    typedef struct packed {
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LD  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e owner;
    } rd_tag_t;

    logic [3:0] wait_cnt_q, wait_cnt_d;
    rd_tag_t    rd_tag_q, rd_tag_d;

    logic       wait_full;
    logic       cpu_gnt;
    logic       ld_gnt;
    mem_cmd_t   mem_cmd;
    logic       cpu_ret;
    logic       ld_ret;

    assign wait_full = (wait_cnt_q == MAX_WAIT_C);

    // -----------------------------------------------------------------------
    // Grant decision. Requests are ignored entirely while in reset.
    // -----------------------------------------------------------------------
    always_comb begin
        cpu_gnt = 1'b0;
        ld_gnt  = 1'b0;
        if (!rst) begin
            if (bus.ld_lock) begin
                ld_gnt = bus.ld_req;
            end else if (wait_full && bus.ld_req) begin
                ld_gnt = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (bus.ld_req) begin
                ld_gnt = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Memory command: the winner's request goes straight to the RAM.
    // Fields are zeroed when nobody wins so the bus is quiet and
    // deterministic; write data is only forwarded for an actual write.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_cmd = '0;
        if (cpu_gnt) begin
            mem_cmd.en   = 1'b1;
            mem_cmd.addr = bus.cpu_addr;
        end else if (ld_gnt) begin
            mem_cmd.en   = 1'b1;
            mem_cmd.we   = bus.ld_we;
            mem_cmd.addr = bus.ld_addr;
            if (bus.ld_we) begin
                mem_cmd.wdata = bus.ld_wdata;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state: anti-starvation counter and read-return tag.
    // The counter only tracks an uninterrupted run of denied loader cycles;
    // any grant or a dropped request starts the count again. Stopping at
    // MAX_WAIT is enough to saturate, since the loader then wins next time.
    // -----------------------------------------------------------------------
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bus.ld_req || ld_gnt) begin
            wait_cnt_d = '0;
        end else if (!wait_full) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        rd_tag_d.vld   = cpu_gnt || (ld_gnt && !bus.ld_we);
        rd_tag_d.owner = ld_gnt ? OWN_LD : OWN_CPU;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            rd_tag_q   <= '{vld: 1'b0, owner: OWN_CPU};
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_tag_q   <= rd_tag_d;
        end
    end

    // -----------------------------------------------------------------------
    // Read return. Gating with rst drops a read whose data would arrive in a
    // reset cycle; the tag itself is cleared on that same edge.
    // -----------------------------------------------------------------------
    assign cpu_ret = rd_tag_q.vld && (rd_tag_q.owner == OWN_CPU) && !rst;
    assign ld_ret  = rd_tag_q.vld && (rd_tag_q.owner == OWN_LD)  && !rst;

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.cpu_stall  = bus.cpu_req && !cpu_gnt && !rst;
    assign bus.cpu_rvalid = cpu_ret;
    assign bus.cpu_rdata  = cpu_ret ? bus.mem_rdata : '0;

    assign bus.ld_gnt     = ld_gnt;
    assign bus.ld_rvalid  = ld_ret;
    assign bus.ld_rdata   = ld_ret ? bus.mem_rdata : '0;

    assign bus.mem_en     = mem_cmd.en;
    assign bus.mem_we     = mem_cmd.we;
    assign bus.mem_addr   = mem_cmd.addr;
    assign bus.mem_wdata  = mem_cmd.wdata;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_prog_mem_arbiter
//   Drives the arbiter through its interface, with a behavioural RAM
//   (preloaded with 0xAA00+addr). Every cycle the outputs are compared with
//   a reference model built from the arbitration rules (integer wait count,
//   shadow memory, pending-return record). On top of that a vector table and
//   a few hand-written sequences check spec-derived constants.
// ---------------------------------------------------------------------------
module tb_prog_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int MW = 4;
    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

    prog_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // behavioural single-port synchronous RAM
    logic [DW-1:0] ram [256];
    logic [DW-1:0] rdq = '0;
    bit            ram_init = 1'b0;
    assign bif.mem_rdata = rdq;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 16'hAA00 + 16'(i);
            ram_init <= 1'b1;
        end else if (bif.mem_en) begin
            if (bif.mem_we) ram[bif.mem_addr] <= bif.mem_wdata;
            else            rdq <= ram[bif.mem_addr];
        end
    end

    typedef struct {
        logic          rst, cpu_req;
        logic [AW-1:0] cpu_addr;
        logic          ld_req, ld_we;
        logic [AW-1:0] ld_addr;
        logic [DW-1:0] ld_wdata;
        logic          ld_lock;
    } stim_t;

    typedef struct {
        stim_t         s;
        logic          cg, lg, crv;
        logic [DW-1:0] crd;
        logic          lrv;
        logic [DW-1:0] lrd;
        logic          stall, mwe;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;

    // reference model state
    int            m_wait     = 0;
    logic          m_ret_vld  = 1'b0;
    logic          m_ret_ld   = 1'b0;
    logic [DW-1:0] m_ret_data = '0;
    logic [DW-1:0] shadow [256];
    logic          last_gc = 1'b0;
    logic          last_gl = 1'b0;

    function automatic stim_t st(input logic r, cr, input logic [AW-1:0] ca,
                                 input logic lr, lw, input logic [AW-1:0] la,
                                 input logic [DW-1:0] lwd, input logic lk);
        stim_t s;
        s.rst = r; s.cpu_req = cr; s.cpu_addr = ca;
        s.ld_req = lr; s.ld_we = lw; s.ld_addr = la; s.ld_wdata = lwd;
        s.ld_lock = lk;
        return s;
    endfunction

    function automatic vec_t v(input stim_t s, input logic cg, lg, crv,
                               input logic [DW-1:0] crd, input logic lrv,
                               input logic [DW-1:0] lrd, input logic stall, mwe);
        vec_t r;
        r.s = s; r.cg = cg; r.lg = lg; r.crv = crv; r.crd = crd;
        r.lrv = lrv; r.lrd = lrd; r.stall = stall; r.mwe = mwe;
        return r;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive after the edge, check at the falling edge
    // against the model, then advance the model across the next edge.
    task automatic step(input stim_t s);
        logic          eg_c, eg_l, ret_ok;
        logic [AW-1:0] eaddr;
        @(posedge clk);
        #1;
        rst          = s.rst;
        bif.cpu_req  = s.cpu_req;
        bif.cpu_addr = s.cpu_addr;
        bif.ld_req   = s.ld_req;
        bif.ld_we    = s.ld_we;
        bif.ld_addr  = s.ld_addr;
        bif.ld_wdata = s.ld_wdata;
        bif.ld_lock  = s.ld_lock;
        @(negedge clk);

        eg_c = 1'b0;
        eg_l = 1'b0;
        if (!s.rst) begin
            if (s.ld_lock)                     eg_l = s.ld_req;
            else if (s.ld_req && m_wait >= MW) eg_l = 1'b1;
            else if (s.cpu_req)                eg_c = 1'b1;
            else                               eg_l = s.ld_req;
        end
        ret_ok = m_ret_vld && !s.rst;
        eaddr  = eg_c ? s.cpu_addr : (eg_l ? s.ld_addr : '0);

        chk1 ("cpu_gnt",    bif.cpu_gnt,    eg_c);
        chk1 ("ld_gnt",     bif.ld_gnt,     eg_l);
        chk1 ("cpu_stall",  bif.cpu_stall,  !s.rst && s.cpu_req && !eg_c);
        chk1 ("cpu_rvalid", bif.cpu_rvalid, ret_ok && !m_ret_ld);
        chk16("cpu_rdata",  bif.cpu_rdata,  (ret_ok && !m_ret_ld) ? m_ret_data : 16'h0);
        chk1 ("ld_rvalid",  bif.ld_rvalid,  ret_ok && m_ret_ld);
        chk16("ld_rdata",   bif.ld_rdata,   (ret_ok && m_ret_ld) ? m_ret_data : 16'h0);
        chk1 ("mem_en",     bif.mem_en,     eg_c || eg_l);
        chk1 ("mem_we",     bif.mem_we,     eg_l && s.ld_we);
        chk16("mem_addr",   16'(bif.mem_addr), 16'(eaddr));
        if (!eg_c && !eg_l)     chk16("mem_wdata_idle",  bif.mem_wdata, 16'h0);
        else if (eg_l && s.ld_we) chk16("mem_wdata_write", bif.mem_wdata, s.ld_wdata);

        if (s.rst) begin
            m_wait    = 0;
            m_ret_vld = 1'b0;
        end else begin
            m_ret_vld  = eg_c || (eg_l && !s.ld_we);
            m_ret_ld   = eg_l;
            m_ret_data = shadow[eg_c ? s.cpu_addr : s.ld_addr];
            if (eg_l && s.ld_we) shadow[s.ld_addr] = s.ld_wdata;
            if (s.ld_req && !eg_l) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
            else                   m_wait = 0;
        end
        last_gc = eg_c;
        last_gl = eg_l;
    endtask

    initial begin
        vec_t  tbl[$];
        stim_t idle, both, both2, cur;

        for (int i = 0; i < 256; i++) shadow[i] = 16'hAA00 + 16'(i);
        bif.cpu_req = 1'b0; bif.cpu_addr = '0; bif.ld_req = 1'b0; bif.ld_we = 1'b0;
        bif.ld_addr = '0; bif.ld_wdata = '0; bif.ld_lock = 1'b0;

        idle = st(N, N, 8'h00, N, N, 8'h00, 16'h0000, N);
        both = st(N, Y, 8'h05, Y, Y, 8'h20, 16'h1234, N);

        //                  stimulus                                              cg lg crv crd        lrv lrd        stl mwe
        tbl.push_back(v(st(Y, Y, 8'h00, Y, Y, 8'h01, 16'hFFFF, N),                N, N, N, 16'h0000, N, 16'h0000, N, N));
        tbl.push_back(v(st(Y, N, 8'h00, N, N, 8'h00, 16'h0000, N),                N, N, N, 16'h0000, N, 16'h0000, N, N));
        tbl.push_back(v(st(N, Y, 8'h00, N, N, 8'h00, 16'h0000, N),                Y, N, N, 16'h0000, N, 16'h0000, N, N));
        tbl.push_back(v(st(N, Y, 8'h01, N, N, 8'h00, 16'h0000, N),                Y, N, Y, 16'hAA00, N, 16'h0000, N, N));
        tbl.push_back(v(st(N, Y, 8'h02, N, N, 8'h00, 16'h0000, N),                Y, N, Y, 16'hAA01, N, 16'h0000, N, N));
        tbl.push_back(v(st(N, Y, 8'h03, N, N, 8'h00, 16'h0000, N),                Y, N, Y, 16'hAA02, N, 16'h0000, N, N));
        tbl.push_back(v(idle,                                                     N, N, Y, 16'hAA03, N, 16'h0000, N, N));
        tbl.push_back(v(st(N, N, 8'h00, Y, Y, 8'h0A, 16'h7F55, N),                N, Y, N, 16'h0000, N, 16'h0000, N, Y));
        tbl.push_back(v(st(N, N, 8'h00, Y, N, 8'h0A, 16'h0000, N),                N, Y, N, 16'h0000, N, 16'h0000, N, N));
        tbl.push_back(v(idle,                                                     N, N, N, 16'h0000, Y, 16'h7F55, N, N));
        tbl.push_back(v(st(N, N, 8'h00, Y, N, 8'h0A, 16'h0000, N),                N, Y, N, 16'h0000, N, 16'h0000, N, N));
        tbl.push_back(v(st(N, Y, 8'h0A, N, N, 8'h00, 16'h0000, N),                Y, N, N, 16'h0000, Y, 16'h7F55, N, N));
        tbl.push_back(v(idle,                                                     N, N, Y, 16'h7F55, N, 16'h0000, N, N));
        tbl.push_back(v(both,                                                     Y, N, N, 16'h0000, N, 16'h0000, N, N));
        tbl.push_back(v(both,                                                     Y, N, Y, 16'hAA05, N, 16'h0000, N, N));
        tbl.push_back(v(both,                                                     Y, N, Y, 16'hAA05, N, 16'h0000, N, N));
        tbl.push_back(v(both,                                                     Y, N, Y, 16'hAA05, N, 16'h0000, N, N));
        tbl.push_back(v(both,                                                     N, Y, Y, 16'hAA05, N, 16'h0000, Y, Y));
        tbl.push_back(v(both,                                                     Y, N, N, 16'h0000, N, 16'h0000, N, N));
        tbl.push_back(v(both,                                                     Y, N, Y, 16'hAA05, N, 16'h0000, N, N));
        tbl.push_back(v(both,                                                     Y, N, Y, 16'hAA05, N, 16'h0000, N, N));
        tbl.push_back(v(both,                                                     Y, N, Y, 16'hAA05, N, 16'h0000, N, N));
        tbl.push_back(v(both,                                                     N, Y, Y, 16'hAA05, N, 16'h0000, Y, Y));
        tbl.push_back(v(idle,                                                     N, N, N, 16'h0000, N, 16'h0000, N, N));

        foreach (tbl[k]) begin
            step(tbl[k].s);
            chk1 ($sformatf("t%0d_cpu_gnt", k),    bif.cpu_gnt,    tbl[k].cg);
            chk1 ($sformatf("t%0d_ld_gnt", k),     bif.ld_gnt,     tbl[k].lg);
            chk1 ($sformatf("t%0d_cpu_rvalid", k), bif.cpu_rvalid, tbl[k].crv);
            chk16($sformatf("t%0d_cpu_rdata", k),  bif.cpu_rdata,  tbl[k].crd);
            chk1 ($sformatf("t%0d_ld_rvalid", k),  bif.ld_rvalid,  tbl[k].lrv);
            chk16($sformatf("t%0d_ld_rdata", k),   bif.ld_rdata,   tbl[k].lrd);
            chk1 ($sformatf("t%0d_cpu_stall", k),  bif.cpu_stall,  tbl[k].stall);
            chk1 ($sformatf("t%0d_mem_we", k),     bif.mem_we,     tbl[k].mwe);
        end

        // ld_lock: a CPU read granted just before the lock still returns;
        // the CPU is held off while three writes land back to back.
        step(st(N, Y, 8'h07, N, N, 8'h00, 16'h0000, N));
        chk1("lk_pre_cpu_gnt", bif.cpu_gnt, Y);
        for (int i = 0; i < 6; i++) begin
            step(st(N, Y, 8'h07, (i < 3), Y, 8'h30 + 8'(i), 16'h5A00 + 16'(i), Y));
            chk1("lk_cpu_gnt",   bif.cpu_gnt,   N);
            chk1("lk_cpu_stall", bif.cpu_stall, Y);
            chk1("lk_ld_gnt",    bif.ld_gnt,    (i < 3));
            chk1("lk_mem_we",    bif.mem_we,    (i < 3));
            if (i == 0) begin
                chk1 ("lk_old_cpu_rvalid", bif.cpu_rvalid, Y);
                chk16("lk_old_cpu_rdata",  bif.cpu_rdata,  16'hAA07);
            end
        end
        step(st(N, Y, 8'h07, N, N, 8'h00, 16'h0000, N));
        chk1("lk_release_cpu_gnt", bif.cpu_gnt,   Y);
        chk1("lk_release_stall",   bif.cpu_stall, N);
        step(st(N, Y, 8'h31, N, N, 8'h00, 16'h0000, N));
        chk16("lk_rd_a7", bif.cpu_rdata, 16'hAA07);
        step(idle);
        chk1 ("lk_rd31_rvalid", bif.cpu_rvalid, Y);
        chk16("lk_rd31_rdata",  bif.cpu_rdata,  16'h5A01);

        // Reset the cycle after a CPU read grant, with the loader part-way
        // through its wait; afterwards the wait count must start from zero.
        both2 = st(N, Y, 8'h09, Y, N, 8'h40, 16'h0000, N);
        step(both2);
        step(both2);
        step(both2);
        chk1("rr_cpu_gnt", bif.cpu_gnt, Y);
        step(st(Y, Y, 8'h09, Y, N, 8'h40, 16'h0000, N));
        chk1("rr_rst_cpu_rvalid", bif.cpu_rvalid, N);
        chk1("rr_rst_cpu_gnt",    bif.cpu_gnt,    N);
        chk1("rr_rst_ld_gnt",     bif.ld_gnt,     N);
        chk1("rr_rst_mem_en",     bif.mem_en,     N);
        chk1("rr_rst_stall",      bif.cpu_stall,  N);
        step(idle);
        chk1 ("rr_post_cpu_rvalid", bif.cpu_rvalid, N);
        chk1 ("rr_post_ld_rvalid",  bif.ld_rvalid,  N);
        chk16("rr_post_cpu_rdata",  bif.cpu_rdata,  16'h0);
        chk16("rr_post_ld_rdata",   bif.ld_rdata,   16'h0);
        chk1 ("rr_post_mem_en",     bif.mem_en,     N);
        for (int i = 0; i < 5; i++) begin
            step(both2);
            chk1("rr_wait_ld_gnt",  bif.ld_gnt,  (i == 4));
            chk1("rr_wait_cpu_gnt", bif.cpu_gnt, (i != 4));
        end

        // Randomised traffic: requests are held until the model grants them.
        cur = idle;
        for (int c = 0; c < 3000; c++) begin
            if (!cur.cpu_req || last_gc) begin
                cur.cpu_req  = ($urandom_range(0, 2) != 0);
                cur.cpu_addr = AW'($urandom_range(0, 15));
            end
            if (!cur.ld_req || last_gl) begin
                cur.ld_req   = ($urandom_range(0, 1) == 1);
                cur.ld_we    = ($urandom_range(0, 1) == 1);
                cur.ld_addr  = AW'($urandom_range(0, 15));
                cur.ld_wdata = DW'($urandom);
            end
            if (cur.ld_lock) cur.ld_lock = ($urandom_range(0, 7) != 0);
            else             cur.ld_lock = ($urandom_range(0, 39) == 0);
            cur.rst = ($urandom_range(0, 149) == 0);
            step(cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/prog_mem_arbiter.md
# prog_mem_arbiter

Shares the single-port synchronous program RAM between the LED CPU instruction-fetch port and the host program-loader port, so that a new LED program can be written, or read back, while the CPU is running. It sits between the CPU fetch interface and the program memory, replacing the CPU's direct ROM connection. CPU fetches have fixed priority. A wait counter prevents the loader from being starved. A lock input lets the loader stall the CPU for a whole download.

## Interface
- ADDR_W, 8, program memory address width
- DATA_W, 16, instruction/data width
- MAX_WAIT, 4, consecutive denied loader cycles before the loader is forced to win (range 1..15)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU fetch request; held with cpu_addr stable until granted
- cpu_addr  in  ADDR_W  fetch address
- cpu_gnt  out  1  CPU request accepted this cycle (combinational)
- cpu_rdata  out  DATA_W  fetched word; valid only while cpu_rvalid=1
- cpu_rvalid  out  1  one-cycle pulse, one cycle after cpu_gnt
- cpu_stall  out  1  cpu_req && !cpu_gnt
- ld_req  in  1  loader request; held with ld_we/addr/wdata stable until granted
- ld_we  in  1  1 = write, 0 = read
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_lock  in  1  while high, the CPU is never granted
- ld_gnt  out  1  loader request accepted this cycle (combinational)
- ld_rdata  out  DATA_W  read-back word; valid only while ld_rvalid=1
- ld_rvalid  out  1  one-cycle pulse, one cycle after a granted loader read
- mem_en, mem_we  out  1  memory enable and write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, one cycle after mem_en with mem_we=0

## Operation
- Each cycle, at most one requester is granted. The winner's request is driven onto the mem_* outputs in the same cycle. When there is no grant: mem_en=0, mem_we=0, and mem_addr and mem_wdata are 0.
- Grant rules, in priority order:
  1. ld_lock=1: the loader wins if ld_req is high; the CPU is never granted.
  2. wait_cnt==MAX_WAIT and ld_req=1: the loader wins.
  3. cpu_req=1: the CPU wins.
  4. ld_req=1: the loader wins.
- wait_cnt is a 4-bit register:
  - Increments when ld_req && !ld_gnt, saturating at MAX_WAIT.
  - Clears on ld_gnt, or when ld_req=0.
- Read return:
  - A registered tag (owner, valid) records each read grant.
  - Next cycle, the matching rvalid pulses and its rdata equals mem_rdata.
  - The non-owner's rdata is driven to 0.
- Loader writes produce no rvalid.
- A requester whose request is not granted simply holds it. There is no timeout and no queueing beyond the request lines themselves.
- Back-to-back grants to the same or different requesters are allowed every cycle, giving full memory throughput.

## Timing
- Reset values: cpu_gnt=0, ld_gnt=0, cpu_rvalid=0, ld_rvalid=0, both rdata=0, cpu_stall=0, wait_cnt=0, read tag invalid.
- Grant latency: 0 cycles (combinational from the request inputs and registered state).
- Read data latency: 1 cycle after grant.
- Reset mid-read: if rst is high in the cycle after a grant, the rvalid pulse is suppressed and the read is lost. The requester must re-issue it.
- Requests are ignored while rst=1: no grants are given, and mem_en=0.
- ld_lock asserted mid-stream: takes effect in the same cycle. A CPU read granted in the previous cycle still returns its cpu_rvalid.
- Simultaneous cpu_req and ld_req with wait_cnt<MAX_WAIT and ld_lock=0: the CPU wins and wait_cnt increments.
- With MAX_WAIT=4 and both requesting continuously, the pattern is 4 CPU grants, then 1 loader grant, repeating.

## Test plan
- Reset, then CPU-only reads of addresses 0x00..0x03 from a memory preloaded with 0xAA00+addr:
  - cpu_gnt is high on each request cycle.
  - cpu_rvalid is high one cycle later with cpu_rdata = 0xAA00..0xAA03.
  - ld_rvalid stays 0 throughout.
- Loader write 0x0A→0x7F55, then loader read of 0x0A:
  - One mem_we pulse occurs, with no ld_rvalid after the write.
  - The read returns ld_rdata=0x7F55 with ld_rvalid one cycle after its grant.
- Continuous cpu_req and ld_req (write) with MAX_WAIT=4:
  - Grant sequence is C,C,C,C,L,C,C,C,C,L.
  - cpu_stall is high only in the L cycles.
- ld_lock=1 with cpu_req held high for 6 cycles and ld_req writing 3 words:
  - cpu_gnt=0 and cpu_stall=1 throughout.
  - The 3 loader writes land on consecutive cycles.
  - After ld_lock falls, cpu_gnt is high in the same cycle.
- CPU read granted at cycle N, with rst asserted at cycle N+1:
  - cpu_rvalid=0 at N+1.
  - All outputs are at their reset values at N+2.
- Loader read and CPU read interleaved (L at N, C at N+1):
  - ld_rvalid at N+1 and cpu_rvalid at N+2, each with the correct data.
  - The other port's rdata is 0 in each of those cycles.
